// File: rtl/card_dealer_arbiter.sv
// Card dealer: arbitrates player/dealer card requests onto one deck read port
// and accumulates blackjack hand values with soft-ace normalisation.
module card_dealer_arbiter #(
    parameter int DECK_SIZE = 52,
    parameter int RD_LAT    = 1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Req_P,
    input  logic       i_Req_D,
    output logic       o_CardOK,
    output logic       o_Grant_P,
    output logic       o_Grant_D,
    output logic [5:0] o_DeckAddr,
    input  logic [3:0] i_DeckCard,
    output logic [5:0] o_HandP,
    output logic [5:0] o_HandD,
    output logic       o_SoftP,
    output logic       o_SoftD,
    output logic       o_DeckEmpty,
    output logic [2:0] o_State
);

    // Handshake: a request is a level held until o_CardOK; o_CardOK then stays
    // high until the granted request is sampled low, and is low in IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t           state, state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic [5:0]       ptr;
    logic [3:0]       card;
    logic [5:0]       hand_p, hand_d;
    logic [5:0]       soft_p, soft_d;
    logic             prio_p;

    logic             deck_empty;
    logic             cur_req;
    logic [5:0]       cur_hand;
    logic [5:0]       cur_soft;
    logic             grant_any;
    logic             grant_d_pick;
    logic             lat_last;
    logic [3:0]       card_val;
    logic [6:0]       sum;
    logic [5:0]       add_hand;
    logic             need_norm;

    always_comb begin
        deck_empty   = (ptr == 6'(DECK_SIZE));
        cur_req      = o_Grant_D ? i_Req_D : i_Req_P;
        cur_hand     = o_Grant_D ? hand_d : hand_p;
        cur_soft     = o_Grant_D ? soft_d : soft_p;
        grant_any    = !deck_empty && (i_Req_P || i_Req_D);
        grant_d_pick = i_Req_D && (!i_Req_P || !prio_p);
        lat_last     = (lat_cnt == LAT_W'(RD_LAT - 1));
        // Out-of-range ranks (0, 14, 15) count as ten-value cards.
        card_val = 4'd10;
        if (card == 4'd1)
            card_val = 4'd11;
        else if (card >= 4'd2 && card <= 4'd9)
            card_val = card;
        sum       = {1'b0, cur_hand} + {3'b000, card_val};
        add_hand  = sum[6] ? 6'd63 : sum[5:0];
        need_norm = (cur_hand > 6'd21) && (cur_soft != 6'd0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_FETCH;
            S_FETCH: if (lat_last) state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM:  if (!need_norm) state_nxt = S_DONE;
            S_DONE:  if (!cur_req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            ptr       <= 6'd0;
            card      <= 4'd0;
            hand_p    <= 6'd0;
            hand_d    <= 6'd0;
            soft_p    <= 6'd0;
            soft_d    <= 6'd0;
            o_Grant_P <= 1'b0;
            o_Grant_D <= 1'b0;
            prio_p    <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    lat_cnt <= '0;
                    if (grant_any) begin
                        o_Grant_P <= !grant_d_pick;
                        o_Grant_D <= grant_d_pick;
                        // Priority only rotates when a tie is actually resolved.
                        if (i_Req_P && i_Req_D)
                            prio_p <= grant_d_pick;
                    end
                end
                S_FETCH: begin
                    if (lat_last) begin
                        card <= i_DeckCard;
                        ptr  <= ptr + 6'd1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_ADD: begin
                    if (o_Grant_D) begin
                        hand_d <= add_hand;
                        if (card == 4'd1) soft_d <= soft_d + 6'd1;
                    end else begin
                        hand_p <= add_hand;
                        if (card == 4'd1) soft_p <= soft_p + 6'd1;
                    end
                end
                S_NORM: begin
                    if (need_norm) begin
                        if (o_Grant_D) begin
                            hand_d <= hand_d - 6'd10;
                            soft_d <= soft_d - 6'd1;
                        end else begin
                            hand_p <= hand_p - 6'd10;
                            soft_p <= soft_p - 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_CardOK    = (state == S_DONE);
    assign o_DeckAddr  = ptr;
    assign o_HandP     = hand_p;
    assign o_HandD     = hand_d;
    assign o_SoftP     = (soft_p != 6'd0);
    assign o_SoftD     = (soft_d != 6'd0);
    assign o_DeckEmpty = deck_empty;
    assign o_State     = state;

endmodule

// File: tb/tb_card_dealer_arbiter.sv
// Directed bench for card_dealer_arbiter: a deck RAM model, request driver
// tasks, and a monitor that checks each o_CardOK rise against a queue.
module tb_card_dealer_arbiter;
    localparam int RD_LAT = 1;
    localparam int W      = 25;

    logic       clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Req_P = 1'b0;
    logic       i_Req_D = 1'b0;
    logic       o_CardOK, o_Grant_P, o_Grant_D, o_SoftP, o_SoftD, o_DeckEmpty;
    logic [5:0] o_DeckAddr, o_HandP, o_HandD;
    logic [3:0] deck_card = 4'd0;
    logic [2:0] o_State;
    logic [3:0] deck_mem [0:63];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic ok_q = 1'b0;
    logic [W-1:0] exp_q[$];

    card_dealer_arbiter #(.DECK_SIZE(52), .RD_LAT(RD_LAT)) dut (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Req_P(i_Req_P), .i_Req_D(i_Req_D),
        .o_CardOK(o_CardOK), .o_Grant_P(o_Grant_P), .o_Grant_D(o_Grant_D),
        .o_DeckAddr(o_DeckAddr), .i_DeckCard(deck_card),
        .o_HandP(o_HandP), .o_HandD(o_HandD), .o_SoftP(o_SoftP), .o_SoftD(o_SoftD),
        .o_DeckEmpty(o_DeckEmpty), .o_State(o_State)
    );

    // clock / RAM model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) deck_card <= deck_mem[o_DeckAddr];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic side, input int hp, input int sp,
                                          input int hd, input int sd, input int addr,
                                          input int lat);
        return {side, 6'(hp), 1'(sp), 6'(hd), 1'(sd), 6'(addr), 4'(lat)};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!i_Reset && o_CardOK && !ok_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cardok", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("grant_d", o_Grant_D, e[24]);
                check("grant_p", o_Grant_P, !e[24]);
                check("hand_p", o_HandP, e[23:18]);
                check("soft_p", o_SoftP, e[17]);
                check("hand_d", o_HandD, e[16:11]);
                check("soft_d", o_SoftD, e[10]);
                check("deck_addr", o_DeckAddr, e[9:4]);
                if (e[3:0] != 4'd0)
                    check("latency", cyc - start_cyc, e[3:0]);
            end
        end
        ok_q = o_CardOK;
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        i_Reset = 1'b1;
        i_Req_P = 1'b0;
        i_Req_D = 1'b0;
        repeat (2) @(negedge clk);
        i_Reset = 1'b0;
    endtask

    task automatic wait_ok(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_CardOK) break;
        end
        if (i == 200) check(name, 0, 1);
    endtask

    task automatic serve(input logic side, input int hp, input int sp, input int hd,
                         input int sd, input int addr, input int lat, input logic early);
        exp_q.push_back(pack(side, hp, sp, hd, sd, addr, lat));
        @(negedge clk);
        start_cyc = cyc;
        if (side) i_Req_D = 1'b1; else i_Req_P = 1'b1;
        if (early) begin
            @(negedge clk);
            i_Req_P = 1'b0;
            i_Req_D = 1'b0;
        end
        wait_ok("cardok_timeout");
        i_Req_P = 1'b0;
        i_Req_D = 1'b0;
        @(negedge clk);
        check("cardok_drop", o_CardOK, 0);
    endtask

    task automatic tie(input logic first, input int hp1, input int hd1, input int a1,
                       input int hp2, input int hd2, input int a2);
        exp_q.push_back(pack(first, hp1, 0, hd1, 0, a1, RD_LAT + 3));
        exp_q.push_back(pack(!first, hp2, 0, hd2, 0, a2, 0));
        @(negedge clk);
        start_cyc = cyc;
        i_Req_P = 1'b1;
        i_Req_D = 1'b1;
        wait_ok("tie_first_timeout");
        if (first) i_Req_D = 1'b0; else i_Req_P = 1'b0;
        @(negedge clk);
        check("tie_cardok_drop", o_CardOK, 0);
        wait_ok("tie_second_timeout");
        i_Req_P = 1'b0;
        i_Req_D = 1'b0;
        @(negedge clk);
        check("tie2_cardok_drop", o_CardOK, 0);
    endtask

    initial begin
        int bad;
        int hp;
        for (int i = 0; i < 64; i++) deck_mem[i] = 4'd0;

        // 1: reset held with both requests high
        deck_mem[0] = 4'd13;
        i_Reset = 1'b1;
        i_Req_P = 1'b1;
        i_Req_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_cardok", o_CardOK, 0);
            check("rst_grants", {o_Grant_P, o_Grant_D}, 0);
            check("rst_addr", o_DeckAddr, 0);
            check("rst_hands", {o_HandP, o_HandD, o_SoftP, o_SoftD}, 0);
            check("rst_empty", o_DeckEmpty, 0);
            check("rst_state", o_State, 0);
        end
        i_Reset = 1'b0;
        i_Req_P = 1'b0;
        i_Req_D = 1'b0;
        @(negedge clk);
        check("post_rst_state", o_State, 0);

        // 2: single king to the player
        serve(1'b0, 10, 0, 0, 0, 1, RD_LAT + 3, 1'b0);

        // 3: soft-ace handling, then dealer cards
        do_reset();
        deck_mem[0] = 4'd1; deck_mem[1] = 4'd1; deck_mem[2] = 4'd9;
        deck_mem[3] = 4'd13; deck_mem[4] = 4'd5; deck_mem[5] = 4'd1;
        serve(1'b0, 11, 1, 0, 0, 1, RD_LAT + 3, 1'b0);
        serve(1'b0, 12, 1, 0, 0, 2, RD_LAT + 4, 1'b0);
        serve(1'b0, 21, 1, 0, 0, 3, RD_LAT + 3, 1'b0);
        serve(1'b0, 21, 0, 0, 0, 4, RD_LAT + 4, 1'b0);
        serve(1'b1, 21, 0, 5, 0, 5, RD_LAT + 3, 1'b0);
        serve(1'b1, 21, 0, 16, 1, 6, RD_LAT + 3, 1'b0);

        // 4: ties, round-robin
        do_reset();
        deck_mem[0] = 4'd2; deck_mem[1] = 4'd3; deck_mem[2] = 4'd4; deck_mem[3] = 4'd5;
        tie(1'b0, 2, 0, 1, 2, 3, 2);
        tie(1'b1, 2, 7, 3, 7, 7, 4);

        // 6: reset during FETCH, then a request dropped mid-transaction
        do_reset();
        deck_mem[0] = 4'd6; deck_mem[1] = 4'd7;
        @(negedge clk);
        i_Req_P = 1'b1;
        @(negedge clk);
        check("fetch_state", o_State, 1);
        i_Reset = 1'b1;
        i_Req_P = 1'b0;
        @(negedge clk);
        i_Reset = 1'b0;
        check("midrst_addr", o_DeckAddr, 0);
        check("midrst_hands", {o_HandP, o_HandD}, 0);
        check("midrst_state", o_State, 0);
        check("midrst_cardok", o_CardOK, 0);
        serve(1'b0, 6, 0, 0, 0, 1, RD_LAT + 3, 1'b0);
        serve(1'b0, 13, 0, 0, 0, 2, RD_LAT + 3, 1'b1);

        // 5: exhaust the deck with ten-value cards; hand saturates at 63
        do_reset();
        for (int i = 0; i < 52; i++) begin
            case (i % 7)
                0: deck_mem[i] = 4'd0;
                1: deck_mem[i] = 4'd14;
                2: deck_mem[i] = 4'd15;
                3: deck_mem[i] = 4'd10;
                4: deck_mem[i] = 4'd11;
                5: deck_mem[i] = 4'd12;
                default: deck_mem[i] = 4'd13;
            endcase
        end
        for (int i = 0; i < 52; i++) begin
            if (i == 51) check("not_empty_yet", o_DeckEmpty, 0);
            hp = (10 * (i + 1) > 63) ? 63 : 10 * (i + 1);
            serve(1'b0, hp, 0, 0, 0, i + 1, RD_LAT + 3, 1'b0);
        end
        check("deck_empty", o_DeckEmpty, 1);
        check("empty_addr", o_DeckAddr, 52);
        bad = 0;
        @(negedge clk);
        i_Req_D = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (o_CardOK || o_Grant_D || o_State != 3'd0) bad++;
        end
        check("empty_no_service", bad, 0);
        check("empty_hand_d", o_HandD, 0);
        check("empty_hand_p", o_HandP, 63);
        check("empty_still", o_DeckEmpty, 1);
        i_Req_D = 1'b0;
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
